// File: rtl/ifu_fetch_if.sv
// ---------------------------------------------------------------------------
// ifu_fetch_if
// Purpose : bundles the two handshake channels of the fetch unit.
//   - memory request/response channel (fetch unit -> instruction memory)
//   - fetched-instruction channel      (fetch unit -> IDU)
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1; the producer holds its payload stable
// while valid=1 and ready=0. The memory response has no ready: memory never
// stalls responses, and the fetch unit always accepts them.
// Signals:
//   o_mem_req_valid / o_mem_req_addr / i_mem_req_ready : fetch request
//   i_mem_rsp_valid / i_mem_rsp_inst                    : fetch response
//   o_ifu_valid / o_ifu_pc / o_ifu_inst / i_idu_ready   : head of fetch buffer
// Modports: master = fetch unit side, slave = memory + IDU side.
// ---------------------------------------------------------------------------
interface ifu_fetch_if #(
  parameter int CPU_WIDTH = 32,
  parameter int INS_WIDTH = 32
);
  logic                 o_mem_req_valid;
  logic [CPU_WIDTH-1:0] o_mem_req_addr;
  logic                 i_mem_req_ready;
  logic                 i_mem_rsp_valid;
  logic [INS_WIDTH-1:0] i_mem_rsp_inst;
  logic                 o_ifu_valid;
  logic [CPU_WIDTH-1:0] o_ifu_pc;
  logic [INS_WIDTH-1:0] o_ifu_inst;
  logic                 i_idu_ready;

  modport master (
    output o_mem_req_valid, o_mem_req_addr,
    input  i_mem_req_ready,
    input  i_mem_rsp_valid, i_mem_rsp_inst,
    output o_ifu_valid, o_ifu_pc, o_ifu_inst,
    input  i_idu_ready
  );

  modport slave (
    input  o_mem_req_valid, o_mem_req_addr,
    output i_mem_req_ready,
    output i_mem_rsp_valid, i_mem_rsp_inst,
    input  o_ifu_valid, o_ifu_pc, o_ifu_inst,
    output i_idu_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Purpose : multi-cycle instruction fetch unit. Issues one fetch request at a
//   time to instruction memory, buffers {pc, inst} pairs in a FIFO and hands
//   them to the IDU. A redirect flushes the buffer and restarts fetch at a new
//   PC; a request already in flight at that point is drained and discarded.
// Ports:
//   i_clk          : clock
//   i_rst          : synchronous active-high reset
//   i_redirect     : flush and restart fetch at i_redirect_pc
//   i_redirect_pc  : redirect target
//   bus            : ifu_fetch_if.master (memory channel + IDU channel)
//   o_dbg_state    : current FSM state (0=REQ, 1=WAIT, 2=DRAIN)
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter int                   CPU_WIDTH  = 32,
  parameter int                   INS_WIDTH  = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = 'h80000000,
  parameter int                   PC_STEP    = 4,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_redirect,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc,
  ifu_fetch_if.master          bus,
  output logic [1:0]           o_dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,  // may issue a request
    ST_WAIT  = 2'd1,  // request in flight, response will be kept
    ST_DRAIN = 2'd2   // request in flight, response will be dropped
  } state_e;

  state_e               state_q, state_d;
  logic [CPU_WIDTH-1:0] fetch_pc_q;
  logic [CPU_WIDTH-1:0] req_pc_q;
  logic [CNT_W-1:0]     count_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CPU_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [INS_WIDTH-1:0] inst_mem_q [FIFO_DEPTH];

  logic not_full;
  logic req_valid;
  logic req_hs;
  logic push;
  logic pop;

  assign not_full  = (count_q < CNT_W'(FIFO_DEPTH));
  // Only one request outstanding: requests are issued from REQ only.
  assign req_valid = !i_rst && (state_q == ST_REQ) && not_full;
  assign req_hs    = req_valid && bus.i_mem_req_ready;
  // A redirect discards both the arriving response and any pop that cycle.
  assign push      = (state_q == ST_WAIT) && bus.i_mem_rsp_valid && !i_redirect;
  assign pop       = (count_q != '0) && bus.i_idu_ready && !i_redirect;

  assign bus.o_mem_req_valid = req_valid;
  assign bus.o_mem_req_addr  = fetch_pc_q;
  assign bus.o_ifu_valid     = (count_q != '0);
  assign bus.o_ifu_pc        = pc_mem_q[rd_ptr_q];
  assign bus.o_ifu_inst      = inst_mem_q[rd_ptr_q];
  assign o_dbg_state         = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_REQ: begin
        // A redirect in the handshake cycle leaves a stale request in flight.
        if (req_hs) state_d = i_redirect ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_mem_rsp_valid) state_d = ST_REQ;
        else if (i_redirect)     state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.i_mem_rsp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;

      if (i_redirect)  fetch_pc_q <= i_redirect_pc;
      else if (req_hs) fetch_pc_q <= fetch_pc_q + CPU_WIDTH'(PC_STEP);

      if (req_hs) req_pc_q <= fetch_pc_q;

      if (i_redirect) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        // A push never meets a full buffer: the request was only issued
        // while a slot was free, and pops only free further slots.
        if (push) begin
          pc_mem_q[wr_ptr_q]   <= req_pc_q;
          inst_mem_q[wr_ptr_q] <= bus.i_mem_rsp_inst;
          wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  localparam int          CW    = 32;
  localparam int          IW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;

  ifu_fetch_if #(.CPU_WIDTH(CW), .INS_WIDTH(IW)) bus ();

  ifu_fetch #(
    .CPU_WIDTH(CW), .INS_WIDTH(IW), .RESET_PC(RPC), .PC_STEP(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .bus(bus), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // counters
  int vectors = 0;
  int miscompares = 0;

  // reference model: buffer contents as a queue of {pc, inst}, plus the
  // memory-side view of the single outstanding request
  logic [63:0] exp_q[$];
  logic [31:0] m_next_pc;
  logic [31:0] m_out_addr;
  bit          m_busy;
  bit          m_stale;
  int          m_rsp_wait;

  // stimulus knobs
  int          p_ready = 100;
  int          p_idu   = 100;
  int          p_redir = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          f_redir = 0;
  logic [31:0] f_target = '0;
  bit          f_stray = 0;
  bit          chk_zero = 0;

  function automatic bit exp_req();
    return !rst && !m_busy && (exp_q.size() < DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic drive();
    bit rsp_due;
    rsp_due = m_busy && (m_rsp_wait == 1);
    bus.i_mem_req_ready = ($urandom_range(0, 99) < p_ready);
    bus.i_idu_ready     = ($urandom_range(0, 99) < p_idu);
    redirect            = f_redir || ((p_redir > 0) && ($urandom_range(0, 99) < p_redir));
    redirect_pc         = f_redir ? f_target : ($urandom & 32'hFFFF_FFFC);
    bus.i_mem_rsp_valid = rsp_due || f_stray;
    bus.i_mem_rsp_inst  = rsp_due ? (m_out_addr ^ 32'h0000_FFFF) : $urandom;
    f_redir = 0;
    f_stray = 0;
  endtask

  // scoreboard: compare outputs against the model
  task automatic check_outputs();
    bit ev;
    ev = exp_req();
    chk("req_valid", 32'(bus.o_mem_req_valid), 32'(ev));
    if (ev) chk("req_addr", bus.o_mem_req_addr, m_next_pc);
    chk("ifu_valid", 32'(bus.o_ifu_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("ifu_pc",   bus.o_ifu_pc,   exp_q[0][63:32]);
      chk("ifu_inst", bus.o_ifu_inst, exp_q[0][31:0]);
    end
    if (chk_zero) begin
      chk("rst_ifu_pc",   bus.o_ifu_pc,   32'h0);
      chk("rst_ifu_inst", bus.o_ifu_inst, 32'h0);
      chk_zero = 0;
    end
  endtask

  // advance the model across one clock edge using this cycle's inputs
  task automatic update_model();
    bit          hs;
    bit          rsp;
    logic [31:0] req_addr;
    if (rst) begin
      exp_q.delete();
      m_next_pc = RPC;
      m_busy    = 0;
      m_stale   = 0;
      return;
    end
    hs       = exp_req() && bus.i_mem_req_ready;
    rsp      = bus.i_mem_rsp_valid;
    req_addr = m_next_pc;
    if (!redirect && (exp_q.size() != 0) && bus.i_idu_ready) void'(exp_q.pop_front());
    if (m_busy) begin
      if (rsp) begin
        if (!m_stale && !redirect) exp_q.push_back({m_out_addr, bus.i_mem_rsp_inst});
        m_busy  = 0;
        m_stale = 0;
      end else begin
        m_rsp_wait--;
        if (redirect) m_stale = 1;
      end
    end else if (hs) begin
      m_busy     = 1;
      m_stale    = redirect;
      m_out_addr = req_addr;
      m_rsp_wait = $urandom_range(lat_min, lat_max);
      m_next_pc  = req_addr + 32'd4;
    end
    if (redirect) begin
      exp_q.delete();
      m_next_pc = redirect_pc;
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    check_outputs();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // bounded wait: mode 0 = in WAIT with no response this cycle,
  // mode 1 = response arriving this cycle, mode 2 = request handshake this cycle
  task automatic wait_for(input int mode, input int max_cycles);
    bit found;
    found = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if ((mode == 0 && m_busy && m_rsp_wait > 1) ||
          (mode == 1 && m_busy && m_rsp_wait == 1) ||
          (mode == 2 && exp_req())) begin
        found = 1;
        break;
      end
      tick();
    end
    if (!found) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    m_next_pc = RPC; m_busy = 0; m_stale = 0; m_rsp_wait = 0; m_out_addr = '0;
    drive();
    @(posedge clk);
    #1;

    // reset state
    chk_zero = 1; tick();
    chk_zero = 1; tick();
    rst = 1'b0;

    // 1-cycle memory, IDU always ready: pc 80000000, ...04, ...08 every 2 cycles
    run(12);

    // IDU stalled: buffer fills, requests stop, head holds; then release
    p_idu = 0;
    run(10);
    p_idu = 100;
    run(8);

    // redirect while waiting on a 2-cycle memory: response dropped (DRAIN)
    lat_min = 2; lat_max = 2;
    wait_for(0, 20);
    f_redir = 1; f_target = 32'h80001000;
    tick();
    run(10);

    // redirect in the same cycle as the response: response dropped
    lat_min = 1; lat_max = 1;
    wait_for(1, 20);
    f_redir = 1; f_target = 32'h80001000;
    tick();
    run(8);

    // redirect coincident with the request handshake
    wait_for(2, 20);
    f_redir = 1; f_target = 32'h80002000;
    tick();
    run(8);

    // address wrap past the top of the address space
    f_redir = 1; f_target = 32'hFFFF_FFF8;
    tick();
    run(10);

    // reset with one entry buffered and a request in flight, late response after
    p_idu = 0; lat_min = 3; lat_max = 3;
    wait_for(0, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero = 1; f_stray = 1;
    lat_min = 1; lat_max = 1; p_idu = 100;
    tick();
    run(8);

    // randomized traffic
    p_ready = 70; p_idu = 60; p_redir = 5; lat_min = 1; lat_max = 4;
    run(400);
    p_redir = 0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
